// File: rtl/arcade_pkg.sv
// Shared types for the ROM download path.
//   rom_word_t  - one SDRAM write: word address, byte-lane enables, data.
//                 The address field is sized for the widest supported
//                 ADDR_W; narrower configurations zero-extend into it.
//   wr_state_e  - SDRAM issue FSM states.
package arcade_pkg;

    localparam int ROM_ADDR_MAX_W = 24;

    typedef struct packed {
        logic [ROM_ADDR_MAX_W-1:0] addr;
        logic [1:0]                ds;
        logic [15:0]               d;
    } rom_word_t;

    localparam int ROM_WORD_W = $bits(rom_word_t);

    typedef enum logic {
        IDLE,
        WAIT
    } wr_state_e;

    localparam logic [1:0] DS_LO   = 2'b01;
    localparam logic [1:0] DS_HI   = 2'b10;
    localparam logic [1:0] DS_BOTH = 2'b11;

endpackage

// File: rtl/rom_word_fifo.sv
// Synchronous word FIFO for packed ROM writes.
//   clk_sys, reset          - clock, synchronous active-high reset (pointers only)
//   push_i, push_word_i     - write request and word
//   pop_i                   - read request; head_o is the current head word
//   full_o, empty_o         - occupancy flags
// A push while full succeeds when a pop happens in the same cycle.
module rom_word_fifo
    import arcade_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [ROM_WORD_W-1:0] push_word_i,
    input  logic                  pop_i,
    output logic [ROM_WORD_W-1:0] head_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [ROM_WORD_W-1:0] mem_q [DEPTH];
    logic                  do_push, do_pop;

    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    assign head_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_word_i;
        end
    end

endmodule

// File: rtl/rom_download_writer.sv
// ROM download writer: packs the data_io ioctl byte stream into 16-bit
// SDRAM writes and issues them over a toggle req/ack port.
//   clk_sys, reset                  - clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout - data_io download stream
//   port_req/ack                    - toggle handshake (done when equal)
//   port_a/ds/we/d                  - SDRAM word address, lanes, enable, data
//   rom_loaded                      - sticky, download fully written
//   busy                            - data held anywhere or write outstanding
//   overflow                        - sticky, a word was dropped (FIFO full)
module rom_download_writer
    import arcade_pkg::*;
#(
    parameter int ROM_INDEX  = 0,
    parameter int ADDR_W     = 23,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              port_req,
    input  logic              port_ack,
    output logic [ADDR_W-1:0] port_a,
    output logic [1:0]        port_ds,
    output logic              port_we,
    output logic [15:0]       port_d,
    output logic              rom_loaded,
    output logic              busy,
    output logic              overflow
);

    localparam logic [7:0] ROM_IDX = 8'(ROM_INDEX);

    function automatic rom_word_t make_word(input logic [ADDR_W-1:0] a,
                                            input logic [1:0] ds,
                                            input logic [15:0] d);
        rom_word_t w;
        w.addr = ROM_ADDR_MAX_W'(a);
        w.ds   = ds;
        w.d    = d;
        return w;
    endfunction

    logic              wr_prev_q, wr_prev_d, dl_prev_q, dl_prev_d;
    logic              dl_armed_q, dl_armed_d, dl_done_q, dl_done_d;
    logic              partial_valid_q, partial_valid_d;
    logic [ADDR_W-1:0] partial_addr_q, partial_addr_d;
    logic [7:0]        partial_byte_q, partial_byte_d;
    logic              pend_valid_q, pend_valid_d;
    rom_word_t         pend_word_q, pend_word_d;
    wr_state_e         state_q, state_d;
    logic              port_req_q, port_req_d, port_we_q, port_we_d;
    logic [ADDR_W-1:0] port_a_q, port_a_d;
    logic [1:0]        port_ds_q, port_ds_d;
    logic [15:0]       port_d_q, port_d_d;
    logic              rom_loaded_q, rom_loaded_d, overflow_q, overflow_d;

    logic                  accept, dl_rise, dl_fall, byte_odd;
    logic [ADDR_W-1:0]     byte_waddr;
    logic                  push, pop, fifo_full, fifo_empty;
    rom_word_t             push_word, flush_word, head;
    logic [ROM_WORD_W-1:0] head_bits;
    logic                  unused_bits;

    assign accept     = ioctl_wr && !wr_prev_q && ioctl_download && (ioctl_index == ROM_IDX);
    assign dl_rise    = ioctl_download && !dl_prev_q;
    assign dl_fall    = !ioctl_download && dl_prev_q;
    assign byte_waddr = ioctl_addr[ADDR_W:1];
    assign byte_odd   = ioctl_addr[0];
    assign flush_word = make_word(partial_addr_q, DS_LO, {8'h00, partial_byte_q});
    assign head       = head_bits;
    assign unused_bits = ^{ioctl_addr, head.addr};

    // Byte packer. When a held partial must be flushed and the new byte is
    // odd, the FIFO would need two pushes in one cycle; the odd word is parked
    // in pend_word and pushed on the next cycle instead (ioctl bytes are at
    // least four cycles apart, so the push slot is free then).
    always_comb begin
        partial_valid_d = partial_valid_q;
        partial_addr_d  = partial_addr_q;
        partial_byte_d  = partial_byte_q;
        pend_valid_d    = 1'b0;
        pend_word_d     = pend_word_q;
        push            = pend_valid_q;
        push_word       = pend_word_q;
        if (accept) begin
            if (!byte_odd) begin
                if (partial_valid_q && partial_addr_q != byte_waddr) begin
                    push      = 1'b1;
                    push_word = flush_word;
                end
                partial_valid_d = 1'b1;
                partial_addr_d  = byte_waddr;
                partial_byte_d  = ioctl_dout;
            end else if (partial_valid_q && partial_addr_q == byte_waddr) begin
                push            = 1'b1;
                push_word       = make_word(byte_waddr, DS_BOTH, {ioctl_dout, partial_byte_q});
                partial_valid_d = 1'b0;
            end else if (partial_valid_q) begin
                push            = 1'b1;
                push_word       = flush_word;
                partial_valid_d = 1'b0;
                pend_valid_d    = 1'b1;
                pend_word_d     = make_word(byte_waddr, DS_HI, {ioctl_dout, 8'h00});
            end else begin
                push      = 1'b1;
                push_word = make_word(byte_waddr, DS_HI, {ioctl_dout, 8'h00});
            end
        end
        if (dl_fall && partial_valid_q) begin
            push            = 1'b1;
            push_word       = flush_word;
            partial_valid_d = 1'b0;
        end
    end

    rom_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .push_i      (push),
        .push_word_i (push_word),
        .pop_i       (pop),
        .head_o      (head_bits),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Issue FSM. A mismatched req/ack seen in IDLE (e.g. straight after a
    // reset that interrupted a write) parks in WAIT without issuing.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        port_req_d = port_req_q;
        port_we_d  = port_we_q;
        port_a_d   = port_a_q;
        port_ds_d  = port_ds_q;
        port_d_d   = port_d_q;
        case (state_q)
            IDLE: begin
                if (port_req_q != port_ack) begin
                    state_d = WAIT;
                end else if (!fifo_empty) begin
                    pop        = 1'b1;
                    port_a_d   = head.addr[ADDR_W-1:0];
                    port_ds_d  = head.ds;
                    port_d_d   = head.d;
                    port_we_d  = 1'b1;
                    port_req_d = ~port_req_q;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (port_req_q == port_ack) begin
                    port_we_d = 1'b0;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    // Download bookkeeping. Only a download whose rising edge was seen since
    // reset can set rom_loaded, so a reset mid-download never reports loaded.
    always_comb begin
        wr_prev_d    = ioctl_wr;
        dl_prev_d    = ioctl_download;
        dl_armed_d   = dl_armed_q;
        dl_done_d    = dl_done_q;
        overflow_d   = overflow_q;
        rom_loaded_d = rom_loaded_q;
        if (dl_rise) begin
            dl_armed_d   = 1'b1;
            dl_done_d    = 1'b0;
            overflow_d   = 1'b0;
            rom_loaded_d = 1'b0;
        end else if (dl_done_q && fifo_empty && !partial_valid_q && !pend_valid_q &&
                     !push && state_q == IDLE) begin
            rom_loaded_d = 1'b1;
        end
        if (dl_fall && dl_armed_q) begin
            dl_armed_d = 1'b0;
            dl_done_d  = 1'b1;
        end
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        port_req_q     <= port_req_d;
        partial_addr_q <= partial_addr_d;
        partial_byte_q <= partial_byte_d;
        pend_word_q    <= pend_word_d;
        if (reset) begin
            wr_prev_q       <= 1'b0;
            dl_prev_q       <= 1'b1;
            dl_armed_q      <= 1'b0;
            dl_done_q       <= 1'b0;
            partial_valid_q <= 1'b0;
            pend_valid_q    <= 1'b0;
            state_q         <= IDLE;
            port_we_q       <= 1'b0;
            port_a_q        <= '0;
            port_ds_q       <= '0;
            port_d_q        <= '0;
            rom_loaded_q    <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            wr_prev_q       <= wr_prev_d;
            dl_prev_q       <= dl_prev_d;
            dl_armed_q      <= dl_armed_d;
            dl_done_q       <= dl_done_d;
            partial_valid_q <= partial_valid_d;
            pend_valid_q    <= pend_valid_d;
            state_q         <= state_d;
            port_we_q       <= port_we_d;
            port_a_q        <= port_a_d;
            port_ds_q       <= port_ds_d;
            port_d_q        <= port_d_d;
            rom_loaded_q    <= rom_loaded_d;
            overflow_q      <= overflow_d;
        end
    end

    assign port_req   = port_req_q;
    assign port_we    = port_we_q;
    assign port_a     = port_a_q;
    assign port_ds    = port_ds_q;
    assign port_d     = port_d_q;
    assign rom_loaded = rom_loaded_q;
    assign overflow   = overflow_q;
    assign busy       = !fifo_empty || partial_valid_q || pend_valid_q || (state_q == WAIT);

endmodule

// File: tb/tb_rom_download_writer.sv
module tb_rom_download_writer;

    localparam int ADDR_W = 23;

    logic              clk_sys = 1'b0;
    logic              reset = 1'b1;
    logic              ioctl_download = 1'b0;
    logic [7:0]        ioctl_index = 8'd0;
    logic              ioctl_wr = 1'b0;
    logic [24:0]       ioctl_addr = '0;
    logic [7:0]        ioctl_dout = 8'd0;
    logic              port_req;
    logic              port_ack = 1'b0;
    logic [ADDR_W-1:0] port_a;
    logic [1:0]        port_ds;
    logic              port_we;
    logic [15:0]       port_d;
    logic              rom_loaded, busy, overflow;

    always #5 clk_sys = ~clk_sys;

    rom_download_writer #(.ROM_INDEX(0), .ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .port_req(port_req), .port_ack(port_ack), .port_a(port_a),
        .port_ds(port_ds), .port_we(port_we), .port_d(port_d),
        .rom_loaded(rom_loaded), .busy(busy), .overflow(overflow)
    );

    typedef struct {
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
        logic        we;
    } issued_t;

    typedef struct {
        int          nb;
        logic [7:0]  idx;
        logic [24:0] ba0, ba1;
        logic [7:0]  bd0, bd1;
        int          nw;
        logic [22:0] wa0, wa1;
        logic [1:0]  ds0, ds1;
        logic [15:0] wd0, wd1;
    } vec_t;

    issued_t iss_q[$];
    vec_t    vecs[6];
    int      n_checks = 0;
    int      n_pass = 0;
    int      stable_bad = 0;
    int      ack_cnt = 0;
    bit      ack_stall = 1'b0;
    bit      mon_en = 1'b0;
    logic    last_req = 1'b0;
    logic    req_before;

    // Request monitor and ack responder, both away from the active edge.
    always @(negedge clk_sys) begin
        if (mon_en) begin
            if (port_req !== last_req) begin
                iss_q.push_back('{port_a, port_ds, port_d, port_we});
                last_req = port_req;
            end else if (port_we && port_req !== port_ack && iss_q.size() > 0) begin
                if (port_a !== iss_q[$].a || port_ds !== iss_q[$].ds || port_d !== iss_q[$].d)
                    stable_bad++;
            end
        end
        if (!ack_stall && port_ack !== port_req) begin
            if (ack_cnt >= 2) begin
                port_ack = port_req;
                ack_cnt  = 0;
            end else begin
                ack_cnt++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
        ioctl_index = idx;
        ioctl_addr  = a;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        cycles(2);
        ioctl_wr    = 1'b0;
        cycles(3);
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        cycles(2);
    endtask

    task automatic wait_loaded(input string name);
        int n = 0;
        while (rom_loaded !== 1'b1 && n < 400) begin
            cycles(1);
            n++;
        end
        check(name, {31'd0, rom_loaded}, 32'd1);
    endtask

    task automatic check_word(input string name, input int i, input logic [22:0] a,
                              input logic [1:0] ds, input logic [15:0] d);
        if (iss_q.size() > i) begin
            check({name, "_addr"}, {9'd0, iss_q[i].a}, {9'd0, a});
            check({name, "_we_ds_d"}, {13'd0, iss_q[i].we, iss_q[i].ds, iss_q[i].d},
                  {13'd0, 1'b1, ds, d});
        end else begin
            check({name, "_present"}, iss_q.size(), i + 1);
        end
    endtask

    task automatic set_vec(input int i, input int nb, input logic [7:0] idx,
                           input logic [24:0] ba0, input logic [7:0] bd0,
                           input logic [24:0] ba1, input logic [7:0] bd1,
                           input int nw,
                           input logic [22:0] wa0, input logic [1:0] ds0, input logic [15:0] wd0,
                           input logic [22:0] wa1, input logic [1:0] ds1, input logic [15:0] wd1);
        vecs[i] = '{nb, idx, ba0, ba1, bd0, bd1, nw, wa0, wa1, ds0, ds1, wd0, wd1};
    endtask

    initial begin
        set_vec(0, 2, 8'd0, 25'd0,  8'h11, 25'd1,  8'h22, 1, 23'd0, 2'b11, 16'h2211, 23'd0,  2'b00, 16'h0000);
        set_vec(1, 2, 8'd0, 25'd8,  8'h01, 25'd20, 8'h02, 2, 23'd4, 2'b01, 16'h0001, 23'd10, 2'b01, 16'h0002);
        set_vec(2, 1, 8'd0, 25'd7,  8'h33, 25'd0,  8'h00, 1, 23'd3, 2'b10, 16'h3300, 23'd0,  2'b00, 16'h0000);
        set_vec(3, 2, 8'd0, 25'd2,  8'h44, 25'd9,  8'h55, 2, 23'd1, 2'b01, 16'h0044, 23'd4,  2'b10, 16'h5500);
        set_vec(4, 2, 8'd1, 25'd0,  8'h66, 25'd1,  8'h77, 0, 23'd0, 2'b00, 16'h0000, 23'd0,  2'b00, 16'h0000);
        set_vec(5, 2, 8'd0, 25'd13, 8'h88, 25'd12, 8'h99, 2, 23'd6, 2'b10, 16'h8800, 23'd6,  2'b01, 16'h0099);

        // Reset state
        cycles(5);
        check("rst_port_we", {31'd0, port_we}, 0);
        check("rst_port_a", {9'd0, port_a}, 0);
        check("rst_port_ds", {30'd0, port_ds}, 0);
        check("rst_port_d", {16'd0, port_d}, 0);
        check("rst_rom_loaded", {31'd0, rom_loaded}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);
        reset = 1'b0;
        last_req = port_req;
        mon_en = 1'b1;
        cycles(3);
        check("post_rst_busy", {31'd0, busy}, 0);

        // Table-driven single downloads
        for (int i = 0; i < 6; i++) begin
            iss_q.delete();
            start_dl();
            check($sformatf("v%0d_loaded_clr", i), {31'd0, rom_loaded}, 0);
            send_byte(vecs[i].idx, vecs[i].ba0, vecs[i].bd0);
            if (vecs[i].nb > 1) send_byte(vecs[i].idx, vecs[i].ba1, vecs[i].bd1);
            ioctl_download = 1'b0;
            wait_loaded($sformatf("v%0d_loaded", i));
            check($sformatf("v%0d_count", i), iss_q.size(), vecs[i].nw);
            if (vecs[i].nw > 0)
                check_word($sformatf("v%0d_w0", i), 0, vecs[i].wa0, vecs[i].ds0, vecs[i].wd0);
            if (vecs[i].nw > 1)
                check_word($sformatf("v%0d_w1", i), 1, vecs[i].wa1, vecs[i].ds1, vecs[i].wd1);
        end

        // Odd-length download: the trailing byte waits for the download end
        iss_q.delete();
        start_dl();
        send_byte(8'd0, 25'd4, 8'hAA);
        send_byte(8'd0, 25'd5, 8'hBB);
        send_byte(8'd0, 25'd6, 8'hCC);
        cycles(10);
        check("odd_count_before_end", iss_q.size(), 1);
        check("odd_busy_partial", {31'd0, busy}, 1);
        check("odd_not_loaded", {31'd0, rom_loaded}, 0);
        ioctl_download = 1'b0;
        wait_loaded("odd_loaded");
        check("odd_count", iss_q.size(), 2);
        check_word("odd_w0", 0, 23'd2, 2'b11, 16'hBBAA);
        check_word("odd_w1", 1, 23'd3, 2'b01, 16'h00CC);

        // Overflow with a stalled ack
        iss_q.delete();
        ack_stall = 1'b1;
        start_dl();
        for (int i = 0; i < 12; i++) send_byte(8'd0, 25'(i), 8'hA0 + 8'(i));
        cycles(40);
        check("ovf_flag", {31'd0, overflow}, 1);
        check("ovf_issued_while_stalled", iss_q.size(), 1);
        ioctl_download = 1'b0;
        cycles(2);
        ack_stall = 1'b0;
        wait_loaded("ovf_loaded");
        check("ovf_count", iss_q.size(), 5);
        for (int k = 0; k < 5; k++)
            check_word($sformatf("ovf_w%0d", k), k, 23'(k), 2'b11,
                       {8'hA1 + 8'(2*k), 8'hA0 + 8'(2*k)});
        check("ovf_sticky", {31'd0, overflow}, 1);
        start_dl();
        check("ovf_cleared_by_new_dl", {31'd0, overflow}, 0);
        ioctl_download = 1'b0;
        wait_loaded("empty_dl_loaded");

        // Reset while a write is outstanding
        iss_q.delete();
        ack_stall = 1'b1;
        start_dl();
        send_byte(8'd0, 25'd0, 8'h11);
        send_byte(8'd0, 25'd1, 8'h22);
        send_byte(8'd0, 25'd2, 8'h33);
        send_byte(8'd0, 25'd3, 8'h44);
        cycles(3);
        req_before = port_req;
        check("rstw_outstanding", {31'd0, port_req ^ port_ack}, 1);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(10);
        check("rstw_no_toggle_stalled", {31'd0, port_req}, {31'd0, req_before});
        check("rstw_we_low", {31'd0, port_we}, 0);
        check("rstw_not_loaded", {31'd0, rom_loaded}, 0);
        ioctl_download = 1'b0;
        cycles(5);
        ack_stall = 1'b0;
        cycles(30);
        check("rstw_no_toggle_after_ack", {31'd0, port_req}, {31'd0, req_before});
        check("rstw_issued", iss_q.size(), 1);
        check("rstw_busy", {31'd0, busy}, 0);
        check("rstw_still_not_loaded", {31'd0, rom_loaded}, 0);

        // A full download after the interrupted one completes normally
        iss_q.delete();
        start_dl();
        send_byte(8'd0, 25'd0, 8'h5A);
        ioctl_download = 1'b0;
        wait_loaded("final_loaded");
        check("final_count", iss_q.size(), 1);
        check_word("final_w0", 0, 23'd0, 2'b01, 16'h005A);

        check("stable_during_wait", stable_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
